// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and the PC / memory / datapath it controls.
// master = sequencer side, slave = environment side.
interface pc_sequencer_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 8
);
    logic              start;
    logic [DWIDTH-1:0] instr_in;
    logic              mem_ready;
    logic              zero_flag;
    logic              pc_en;
    logic [1:0]        pc_ctrl;
    logic [AWIDTH-1:0] pc_offset;
    logic              mem_addr_sel;
    logic              mem_rd;
    logic              mem_wr;
    logic              ir_load;
    logic              acc_load;
    logic [2:0]        alu_op;
    logic              halted;
    logic              illegal_op;

    modport master (
        input  start, instr_in, mem_ready, zero_flag,
        output pc_en, pc_ctrl, pc_offset, mem_addr_sel, mem_rd, mem_wr,
               ir_load, acc_load, alu_op, halted, illegal_op
    );

    modport slave (
        output start, instr_in, mem_ready, zero_flag,
        input  pc_en, pc_ctrl, pc_offset, mem_addr_sel, mem_rd, mem_wr,
               ir_load, acc_load, alu_op, halted, illegal_op
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving PC update, memory requests
// and accumulator strobes; exactly one PC update per non-HALT instruction.
module pc_sequencer #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.master bus
);
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StHalt   = 3'd4;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpLda  = 4'd1;
    localparam logic [3:0] OpSta  = 4'd2;
    localparam logic [3:0] OpAdd  = 4'd3;
    localparam logic [3:0] OpSub  = 4'd4;
    localparam logic [3:0] OpJmp  = 4'd5;
    localparam logic [3:0] OpJz   = 4'd6;
    localparam logic [3:0] OpHalt = 4'd7;

    localparam logic [1:0] PcHold = 2'b00;
    localparam logic [1:0] PcInc  = 2'b01;
    localparam logic [1:0] PcLoad = 2'b10;

    localparam logic [2:0] AluPass = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;

    // Only the opcode and operand fields of IR are ever consumed.
    logic [2:0]        state_q, state_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [AWIDTH-1:0] operand_q, operand_d;
    logic              illegal_q, illegal_d;

    logic       pc_en, addr_sel, rd, wr, ir_load, acc_load, halted;
    logic [1:0] pc_ctrl;
    logic [2:0] alu_op;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        illegal_d = illegal_q;
        pc_en     = 1'b0;
        pc_ctrl   = PcHold;
        addr_sel  = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        ir_load   = 1'b0;
        acc_load  = 1'b0;
        alu_op    = AluPass;
        halted    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StFetch;
            end
            StFetch: begin
                rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_load   = 1'b1;
                    opcode_d  = bus.instr_in[DWIDTH-1 -: 4];
                    operand_d = bus.instr_in[AWIDTH-1:0];
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                state_d = StExec;
            end
            StExec: begin
                case (opcode_q)
                    OpNop: begin
                        pc_en   = 1'b1;
                        pc_ctrl = PcInc;
                        state_d = StFetch;
                    end
                    OpLda, OpAdd, OpSub: begin
                        rd       = 1'b1;
                        addr_sel = 1'b1;
                        if (bus.mem_ready) begin
                            acc_load = 1'b1;
                            pc_en    = 1'b1;
                            pc_ctrl  = PcInc;
                            state_d  = StFetch;
                            if (opcode_q == OpAdd)      alu_op = AluAdd;
                            else if (opcode_q == OpSub) alu_op = AluSub;
                            else                        alu_op = AluPass;
                        end
                    end
                    OpSta: begin
                        wr       = 1'b1;
                        addr_sel = 1'b1;
                        if (bus.mem_ready) begin
                            pc_en   = 1'b1;
                            pc_ctrl = PcInc;
                            state_d = StFetch;
                        end
                    end
                    OpJmp: begin
                        pc_en   = 1'b1;
                        pc_ctrl = PcLoad;
                        state_d = StFetch;
                    end
                    OpJz: begin
                        pc_en   = 1'b1;
                        pc_ctrl = bus.zero_flag ? PcLoad : PcInc;
                        state_d = StFetch;
                    end
                    OpHalt: begin
                        state_d = StHalt;
                    end
                    default: begin
                        // Undefined opcodes behave as NOP but latch the error flag.
                        pc_en     = 1'b1;
                        pc_ctrl   = PcInc;
                        illegal_d = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            opcode_q  <= '0;
            operand_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are forced low while reset is held, independent of clocking.
    assign bus.pc_en        = pc_en & ~rst;
    assign bus.pc_ctrl      = rst ? PcHold : pc_ctrl;
    assign bus.pc_offset    = rst ? '0 : operand_q;
    assign bus.mem_addr_sel = addr_sel & ~rst;
    assign bus.mem_rd       = rd & ~rst;
    assign bus.mem_wr       = wr & ~rst;
    assign bus.ir_load      = ir_load & ~rst;
    assign bus.acc_load     = acc_load & ~rst;
    assign bus.alu_op       = rst ? AluPass : alu_op;
    assign bus.halted       = halted & ~rst;
    assign bus.illegal_op   = illegal_q & ~rst;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fixed instruction sequence with hand-computed
// strobe patterns checked by immediate assertions.
module tb_pc_sequencer;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    pc_sequencer_if #(.DWIDTH(16), .AWIDTH(8)) bus ();

    pc_sequencer #(.DWIDTH(16), .AWIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Checks every strobe output in one comparison; settles combinational inputs first.
    task automatic expect_out(input string tag, input bit en, input bit [1:0] ctrl,
                              input bit sel, input bit rd, input bit wr, input bit irl,
                              input bit accl, input bit [2:0] alu, input bit hlt,
                              input bit ill);
        logic [12:0] obs;
        logic [12:0] exp;
        #1;
        obs = {bus.pc_en, bus.pc_ctrl, bus.mem_addr_sel, bus.mem_rd, bus.mem_wr,
               bus.ir_load, bus.acc_load, bus.alu_op, bus.halted, bus.illegal_op};
        exp = {en, ctrl, sel, rd, wr, irl, accl, alu, hlt, ill};
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (en,ctrl,sel,rd,wr,irl,acc,alu,hlt,ill)",
                   tag, obs, exp);
        end
    endtask

    task automatic expect_off(input string tag, input logic [7:0] exp);
        n_assert++;
        assert (bus.pc_offset === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed pc_offset %h expected %h", tag, bus.pc_offset, exp);
        end
    endtask

    // One instruction with mem_ready=1 throughout and a single-cycle EXEC.
    task automatic fetch_decode(input string tag, input logic [15:0] instr, input bit ill);
        bus.instr_in  = instr;
        bus.mem_ready = 1'b1;
        expect_out({tag, "_fetch"}, 0, 2'b00, 0, 1, 0, 1, 0, 3'b000, 0, ill);
        tick();
        expect_out({tag, "_decode"}, 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, ill);
        tick();
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.instr_in  = 16'h5042;
        bus.mem_ready = 1'b1;
        bus.zero_flag = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        expect_out("reset_held", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        expect_off("reset_offset", 8'h00);
        rst = 1'b0;
        expect_out("idle", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);

        // Three NOPs: ir_load on cycles 1,4,7 after start, pc_en on 3,6,9.
        bus.start    = 1'b1;
        bus.instr_in = 16'h0000;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_decode("nop", 16'h0000, 0);
            expect_out("nop_exec", 1, 2'b01, 0, 0, 0, 0, 0, 3'b000, 0, 0);
            tick();
        end

        fetch_decode("jmp", 16'h5042, 0);
        expect_out("jmp_exec", 1, 2'b10, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        expect_off("jmp_offset", 8'h42);
        tick();

        bus.zero_flag = 1'b1;
        fetch_decode("jz1", 16'h6010, 0);
        expect_out("jz_taken", 1, 2'b10, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        expect_off("jz_offset", 8'h10);
        tick();
        bus.zero_flag = 1'b0;
        fetch_decode("jz0", 16'h6010, 0);
        expect_out("jz_not_taken", 1, 2'b01, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        tick();

        // ADD with two memory wait cycles in EXEC.
        fetch_decode("add", 16'h3020, 0);
        bus.mem_ready = 1'b0;
        expect_out("add_stall1", 0, 2'b00, 1, 1, 0, 0, 0, 3'b000, 0, 0);
        tick();
        expect_out("add_stall2", 0, 2'b00, 1, 1, 0, 0, 0, 3'b000, 0, 0);
        tick();
        bus.mem_ready = 1'b1;
        expect_out("add_ready", 1, 2'b01, 1, 1, 0, 0, 1, 3'b001, 0, 0);
        tick();

        fetch_decode("lda", 16'h1005, 0);
        expect_out("lda_exec", 1, 2'b01, 1, 1, 0, 0, 1, 3'b000, 0, 0);
        tick();
        fetch_decode("sub", 16'h4007, 0);
        expect_out("sub_exec", 1, 2'b01, 1, 1, 0, 0, 1, 3'b010, 0, 0);
        tick();
        fetch_decode("sta", 16'h2033, 0);
        bus.mem_ready = 1'b0;
        expect_out("sta_stall", 0, 2'b00, 1, 0, 1, 0, 0, 3'b000, 0, 0);
        tick();
        bus.mem_ready = 1'b1;
        expect_out("sta_ready", 1, 2'b01, 1, 0, 1, 0, 0, 3'b000, 0, 0);
        tick();

        fetch_decode("halt", 16'h7000, 0);
        expect_out("halt_exec", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        expect_out("halted", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0);
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        expect_out("halt_ignores_start", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0);
        rst = 1'b1;
        expect_out("halt_reset", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        rst = 1'b0;
        expect_out("idle_after_halt", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);

        // Undefined opcode, then reset during a stalled fetch.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        fetch_decode("ill", 16'hF000, 0);
        expect_out("ill_exec", 1, 2'b01, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        bus.mem_ready = 1'b0;
        expect_out("ill_sticky_fetch", 0, 2'b00, 0, 1, 0, 0, 0, 3'b000, 0, 1);
        tick();
        expect_out("fetch_stall", 0, 2'b00, 0, 1, 0, 0, 0, 3'b000, 0, 1);
        rst = 1'b1;
        expect_out("reset_mid_fetch", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        expect_off("reset_mid_fetch_offset", 8'h00);
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        expect_out("idle_after_reset", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        tick();
        expect_out("idle_stays", 0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control sequencer that drives the program counter's enable/control/offset interface. It sits between instruction memory, the PC, the accumulator/ALU datapath and data memory. The block fetches an instruction at the PC, decodes it, and issues datapath strobes. It then tells the PC to increment or load a jump target, exactly once per instruction.

Parameters:
DWIDTH, 16, instruction/data word width
AWIDTH, 8, operand/jump address width; instruction field IR[AWIDTH-1:0]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  leave IDLE and begin fetching
instr_in  input  DWIDTH  instruction word from instruction memory
mem_ready  input  1  memory access complete this cycle (instruction or data)
zero_flag  input  1  accumulator-zero flag from ALU
pc_en  output  1  PC update enable
pc_ctrl  output  2  01 = increment, 10 = load pc_offset, 00 = hold
pc_offset  output  AWIDTH  jump target, always IR[AWIDTH-1:0]
mem_addr_sel  output  1  0 = memory address from PC, 1 = from IR operand
mem_rd  output  1  memory read request
mem_wr  output  1  memory write request
ir_load  output  1  instruction captured this cycle
acc_load  output  1  accumulator write strobe
alu_op  output  3  000 PASS, 001 ADD, 010 SUB
halted  output  1  sequencer in HALT
illegal_op  output  1  sticky: undefined opcode executed

Behaviour:
- One clock. Async active-high reset: state=IDLE, IR=0, illegal_op=0.
- All outputs are combinational from registered state/IR/inputs. While rst=1, every output is 0 (pc_offset=0).
- States: IDLE, FETCH, DECODE, EXEC, HALT. Opcode = IR[15:12].
- IDLE:
  - All strobes 0.
  - start=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - mem_rd=1, mem_addr_sel=0.
  - If mem_ready=1: ir_load=1, IR<=instr_in, go to DECODE.
  - Else stay in FETCH, no IR change.
- DECODE:
  - No strobes; one cycle.
  - Next state is EXEC.
- EXEC, per opcode:
  - 0 NOP: pc_en=1, pc_ctrl=01.
  - 1 LDA: mem_rd=1, mem_addr_sel=1. Stall until mem_ready. In the ready cycle: acc_load=1, alu_op=000, pc_en=1, pc_ctrl=01.
  - 2 STA: mem_wr=1, mem_addr_sel=1. Stall until mem_ready, then pc_en=1, pc_ctrl=01.
  - 3 ADD: as LDA with alu_op=001.
  - 4 SUB: as LDA with alu_op=010.
  - 5 JMP: pc_en=1, pc_ctrl=10.
  - 6 JZ: pc_en=1. pc_ctrl=10 if zero_flag=1 else 01. zero_flag is sampled in the EXEC cycle.
  - 7 HALT: pc_en=0 -> HALT.
  - 8-15: treated as NOP; illegal_op set to 1 on that edge.
  - Leaving EXEC (not HALT) -> FETCH.
- During an EXEC stall: pc_en=0, acc_load=0, pc_ctrl=00; request held asserted.
- HALT:
  - halted=1, all other strobes 0.
  - start is ignored; only rst exits.
- Invariants:
  - pc_en asserts only in EXEC, exactly one cycle per non-HALT instruction.
  - pc_en=0 implies pc_ctrl=00.
  - mem_rd and mem_wr are never both 1.
- Latency with mem_ready tied 1:
  - NOP/JMP/JZ: 3 cycles per instruction.
  - LDA/STA/ADD/SUB: 3 cycles per instruction.
  - Each memory wait cycle adds 1.
- Reset asserted mid-stall or mid-fetch aborts immediately. No pc_en or acc_load is emitted on the way out.
- illegal_op clears only on rst.

Test Plan:
- Reset, start pulse, mem_ready=1, instr=0x0000 ×3 -> pc_en pulse every 3rd cycle with pc_ctrl=01; ir_load on cycles 1, 4, 7 after start.
- instr=0x5042 (JMP) -> in EXEC: pc_en=1, pc_ctrl=10, pc_offset=0x42.
- JZ 0x6010 with zero_flag=1 -> pc_ctrl=10, pc_offset=0x10. Repeat with zero_flag=0 -> pc_ctrl=01.
- ADD 0x3020 with mem_ready low 2 cycles in EXEC:
  - mem_rd=1 and mem_addr_sel=1 for 3 cycles.
  - acc_load=1 and alu_op=001 only in the third cycle, together with pc_en.
- HALT 0x7000 -> halted=1, no further pc_en; start pulses ignored. Assert rst -> IDLE with halted=0.
- Opcode 0xF000 -> illegal_op=1 and pc increments. Then rst asserted during a FETCH stall -> all outputs 0 immediately and illegal_op=0.
